dec38_hold_disp: RTL

DEC38_HOLD_DISP -- requirements
Module: dec38_hold_disp

---
 rtl/dec38_hold_disp.sv | 124 ++++++++++++
 1 files changed

// File: rtl/dec38_hold_disp.sv
// 3-to-8 decoder that holds each accepted code on a one-hot and seven-segment
// display for HOLD_CYCLES cycles, then forces GAP_CYCLES idle cycles.
module dec38_hold_disp #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_enable,
    input  logic       i_valid,
    input  logic [2:0] i_code,
    output logic       o_ready,
    output logic [7:0] o_onehot,
    output logic [7:0] o_seg,
    output logic       o_busy,
    output logic [7:0] o_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);
    localparam bit         HAS_GAP   = (GAP_CYCLES > 0);

    state_t     r_state, w_state_next;
    logic [7:0] r_hold_cnt, w_hold_cnt_next;
    logic [2:0] r_code, w_code_next;
    logic [7:0] r_count, w_count_next;
    logic       w_in_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= 8'd0;
            r_code     <= 3'd0;
            r_count    <= 8'd0;
        end else begin
            r_state    <= w_state_next;
            r_hold_cnt <= w_hold_cnt_next;
            r_code     <= w_code_next;
            r_count    <= w_count_next;
        end
    end

    // Abort on a low enable is tested before expiry so it always wins.
    always_comb begin
        w_state_next    = r_state;
        w_hold_cnt_next = r_hold_cnt;
        w_code_next     = r_code;
        w_count_next    = r_count;
        case (r_state)
            S_IDLE: begin
                if (i_enable && i_valid) begin
                    w_state_next    = S_HOLD;
                    w_hold_cnt_next = HOLD_LOAD;
                    w_code_next     = i_code;
                    w_count_next    = r_count + 8'd1;
                end
            end
            S_HOLD: begin
                if (!i_enable) begin
                    w_state_next    = S_IDLE;
                    w_hold_cnt_next = 8'd0;
                end else if (r_hold_cnt == 8'd0) begin
                    if (HAS_GAP) begin
                        w_state_next    = S_GAP;
                        w_hold_cnt_next = GAP_LOAD;
                    end else begin
                        w_state_next    = S_IDLE;
                        w_hold_cnt_next = 8'd0;
                    end
                end else begin
                    w_hold_cnt_next = r_hold_cnt - 8'd1;
                end
            end
            S_GAP: begin
                if (!i_enable || (r_hold_cnt == 8'd0)) begin
                    w_state_next    = S_IDLE;
                    w_hold_cnt_next = 8'd0;
                end else begin
                    w_hold_cnt_next = r_hold_cnt - 8'd1;
                end
            end
            default: begin
                w_state_next    = S_IDLE;
                w_hold_cnt_next = 8'd0;
            end
        endcase
    end

    // rst_n gates ready so it is low throughout reset, not just after an edge.
    assign o_ready   = rst_n && (r_state == S_IDLE) && i_enable;
    assign w_in_hold = (r_state == S_HOLD);
    assign o_busy    = (r_state == S_HOLD) || (r_state == S_GAP);
    assign o_count   = r_count;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_onehot
            assign o_onehot[gi] = w_in_hold && (r_code == 3'(gi));
        end
    endgenerate

    always_comb begin
        o_seg = 8'hFF;
        if (w_in_hold) begin
            case (r_code)
                3'd0: o_seg = 8'hC0;
                3'd1: o_seg = 8'hF9;
                3'd2: o_seg = 8'hA4;
                3'd3: o_seg = 8'hB0;
                3'd4: o_seg = 8'h99;
                3'd5: o_seg = 8'h92;
                3'd6: o_seg = 8'h82;
                3'd7: o_seg = 8'hF8;
                default: o_seg = 8'hFF;
            endcase
        end
    end

endmodule
